bin_to_display_digits: RTL and testbench
========================================

// Module: bin_to_display_digits
// PURPOSE
//  Sequential binary-to-7-segment front end for the 4-digit multiplexed display driver.
//  Converts an unsigned binary value to 4 BCD digits with a shift-add-3 (double-dabble) FSM,
//  encodes each digit to 7 segments and generates per-digit enables with leading-zero blanking.
//  Drives the driver's indicator0..3 / enable inputs directly; outputs are registered and held stable between conversions.
// PARAMETERS
//  BIN_WIDTH  14  width of value; legal 4..14
//  BLANK_LZ   1   1 = blank leading zero digits, 0 = all four digits always enabled
// PORTS
//  clk         in   1  system clock, all state on posedge
//  reset       in   1  asynchronous, active-high reset
//  start       in   1  request conversion of value; sampled only in IDLE
//  value       in   BIN_WIDTH  unsigned binary input, captured on the accepting edge
//  busy        out  1  conversion in progress
//  done        out  1  one-clock pulse: new indicator/enable values valid
//  overflow    out  1  last accepted value > 9999
//  indicator0  out  7  segments of digit 0 (units), bit0=a .. bit6=g, active-high
//  indicator1  out  7  segments of digit 1 (tens)
//  indicator2  out  7  segments of digit 2 (hundreds)
//  indicator3  out  7  segments of digit 3 (thousands)
//  enable      out  4  per-digit enable, bit k -> indicatork
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, busy=0, done=0, overflow=0, indicator0=7'b0111111 ("0"),
//    indicator1..3=7'b0000000, enable=4'b0001; any conversion in flight is abandoned.
//  - FSM IDLE -> CONVERT -> ENCODE -> IDLE.
//    IDLE: start=1 at edge N captures value into shift reg, clears 16-bit BCD reg, latches
//      overflow_pending=(value>9999), loads bit counter=BIN_WIDTH, -> CONVERT; busy=1 from edge N.
//    CONVERT: each edge, every BCD nibble >=5 gets +3, then {bcd,shift} shifts left one bit;
//      counter decrements; after BIN_WIDTH edges -> ENCODE.
//    ENCODE: one edge; registers indicator0..3, enable, overflow; done=1, busy=0; -> IDLE.
//  - Latency: done is high in the cycle after edge N+BIN_WIDTH+1 (BIN_WIDTH+2 edges after accept
//    edge N, inclusive); done lasts exactly one clock.
//  - start while busy=1 is ignored (not queued). start high during the done cycle is accepted
//    (FSM is already IDLE), giving back-to-back conversions with no idle gap.
//  - indicator/enable/overflow change only on the ENCODE edge; never show intermediate BCD.
//  - Segment map (g..a): 0=0111111 1=0000110 2=1011011 3=1001111 4=1100110
//    5=1101101 6=1111101 7=0000111 8=1111111 9=1101111.
//  - Blanking (BLANK_LZ=1): enable[3]=d3!=0; enable[2]=enable[3]|d2!=0; enable[1]=enable[2]|d1!=0;
//    enable[0]=1 always. Blanked digits also drive indicatork=7'b0000000. BLANK_LZ=0: enable=4'b1111.
//  - Overflow (value>9999, only reachable with BIN_WIDTH=14): full latency still taken; overflow=1,
//    all indicators=7'b1000000 (dash "-"), enable=4'b1111 regardless of BLANK_LZ. Next in-range
//    conversion clears overflow on its ENCODE edge.
//  - Arithmetic: BCD reg 16 bits (4 nibbles), add-3 is per-nibble 4-bit, no carry between nibbles;
//    BCD content is don't-care when overflow.
// TESTING
//  1 value=1234, start 1 clk -> done after 16 edges (BIN_WIDTH=14); ind3..0=0000110,1011011,
//    1001111,1100110; enable=1111; overflow=0; busy high exactly 15 cycles before done.
//  2 value=7 -> ind0=0000111, ind1..3=0000000, enable=0001; value=0 -> ind0=0111111, enable=0001;
//    value=405 -> enable=0111, ind1=0111111 (internal zero shown).
//  3 value=10000 -> overflow=1, all ind=1000000, enable=1111; then value=9999 -> overflow=0,
//    all ind=1101111, enable=1111.
//  4 start pulses while busy with value changing -> ignored; result matches first captured value;
//    start held high through done cycle -> second conversion accepted, second done 16 edges later.
//  5 reset asserted mid-CONVERT (async, between edges) -> outputs at reset values immediately, busy=0,
//    no done; after release, start with value=42 -> ind1=1100110, ind0=1011011, enable=0011.
//  6 BLANK_LZ=0, value=7 -> enable=1111, ind3..1=0111111; BIN_WIDTH=4, value=15 -> done after 6 edges,
//    ind1=0000110, ind0=1101101, enable=0011.

Source files
------------

// File: rtl/bin_to_display_digits.sv
// Sequential binary-to-7-segment front end for a 4-digit multiplexed display.
// A double-dabble FSM turns value into four BCD digits; the ENCODE step then
// registers segment patterns, per-digit enables and the overflow flag together.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting for start; outputs hold the last encoded result
// S_CONVERT | one shift-add-3 step per clock, BIN_WIDTH steps total
// S_ENCODE  | BCD is final; segments/enables/overflow registered, done pulses

module bin_to_display_digits #(
  parameter int BIN_WIDTH = 14,
  parameter bit BLANK_LZ  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] value,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [6:0]           indicator0,
  output logic [6:0]           indicator1,
  output logic [6:0]           indicator2,
  output logic [6:0]           indicator3,
  output logic [3:0]           enable
);

  localparam int         CNT_W    = $clog2(BIN_WIDTH + 1);
  localparam logic [6:0] SEG_OFF  = 7'b0000000;
  localparam logic [6:0] SEG_ZERO = 7'b0111111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_ENCODE  = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [BIN_WIDTH-1:0] shift_q, shift_nxt;
  logic [15:0]          bcd_q, bcd_nxt, bcd_adj;
  logic [CNT_W-1:0]     cnt_q, cnt_nxt;
  logic                 ovf_pend_q, ovf_pend_nxt;
  logic                 encode;
  logic [15:0]          value_ext;

  logic [3:0]           digit [4];
  logic [3:0]           nz;
  logic [3:0]           en_nxt;
  logic [6:0]           ind_nxt [4];

  assign value_ext = 16'(value);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  // Per-nibble add-3 correction; nibbles are independent, no carry between them
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      else
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and datapath next values; the bit counter is a down-counter
  // whose terminal count of 1 marks the final shift step
  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift_q;
    bcd_nxt      = bcd_q;
    cnt_nxt      = cnt_q;
    ovf_pend_nxt = ovf_pend_q;
    encode       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          shift_nxt    = value;
          bcd_nxt      = '0;
          cnt_nxt      = CNT_W'(BIN_WIDTH);
          ovf_pend_nxt = (value_ext > 16'd9999);
          state_nxt    = S_CONVERT;
        end
      end
      S_CONVERT: begin
        // Top BCD bit falls off; only matters for out-of-range values,
        // which are displayed as dashes anyway
        bcd_nxt   = 16'({bcd_adj, shift_q[BIN_WIDTH-1]});
        shift_nxt = {shift_q[BIN_WIDTH-2:0], 1'b0};
        cnt_nxt   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1))
          state_nxt = S_ENCODE;
      end
      S_ENCODE: begin
        encode    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Conversion datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
    end else begin
      shift_q    <= shift_nxt;
      bcd_q      <= bcd_nxt;
      cnt_q      <= cnt_nxt;
      ovf_pend_q <= ovf_pend_nxt;
    end
  end

  // Digit split, leading-zero blanking and segment encoding of the final BCD
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      digit[k] = bcd_q[4*k +: 4];
      nz[k]    = (digit[k] != 4'd0);
    end
    if (ovf_pend_q) begin
      en_nxt = 4'b1111;
      for (int k = 0; k < 4; k++) ind_nxt[k] = SEG_DASH;
    end else begin
      if (BLANK_LZ)
        en_nxt = {nz[3], nz[3] | nz[2], nz[3] | nz[2] | nz[1], 1'b1};
      else
        en_nxt = 4'b1111;
      for (int k = 0; k < 4; k++)
        ind_nxt[k] = en_nxt[k] ? seg7(digit[k]) : SEG_OFF;
    end
  end

  // Status outputs: busy tracks any non-idle state, done pulses after ENCODE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt != S_IDLE);
      done <= encode;
    end
  end

  // Display outputs update only on the ENCODE edge so no partial BCD is shown
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      enable     <= 4'b0001;
      indicator0 <= SEG_ZERO;
      indicator1 <= SEG_OFF;
      indicator2 <= SEG_OFF;
      indicator3 <= SEG_OFF;
    end else if (encode) begin
      overflow   <= ovf_pend_q;
      enable     <= en_nxt;
      indicator0 <= ind_nxt[0];
      indicator1 <= ind_nxt[1];
      indicator2 <= ind_nxt[2];
      indicator3 <= ind_nxt[3];
    end
  end

endmodule

// File: tb/tb_bin_to_display_digits.sv
// Randomized self-checking bench for bin_to_display_digits. Three instances:
// default (14-bit, blanking), blanking disabled, and a 4-bit variant.

module tb_bin_to_display_digits;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        start_a, busy_a, done_a, ovf_a;
  logic [13:0] value_a;
  logic [6:0]  i0_a, i1_a, i2_a, i3_a;
  logic [3:0]  en_a;

  logic        start_b, busy_b, done_b, ovf_b;
  logic [13:0] value_b;
  logic [6:0]  i0_b, i1_b, i2_b, i3_b;
  logic [3:0]  en_b;

  logic        start_c, busy_c, done_c, ovf_c;
  logic [3:0]  value_c;
  logic [6:0]  i0_c, i1_c, i2_c, i3_c;
  logic [3:0]  en_c;

  bin_to_display_digits #(.BIN_WIDTH(14), .BLANK_LZ(1'b1)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .value(value_a),
    .busy(busy_a), .done(done_a), .overflow(ovf_a),
    .indicator0(i0_a), .indicator1(i1_a), .indicator2(i2_a), .indicator3(i3_a),
    .enable(en_a)
  );

  bin_to_display_digits #(.BIN_WIDTH(14), .BLANK_LZ(1'b0)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .value(value_b),
    .busy(busy_b), .done(done_b), .overflow(ovf_b),
    .indicator0(i0_b), .indicator1(i1_b), .indicator2(i2_b), .indicator3(i3_b),
    .enable(en_b)
  );

  bin_to_display_digits #(.BIN_WIDTH(4), .BLANK_LZ(1'b1)) u_dut_c (
    .clk(clk), .reset(reset), .start(start_c), .value(value_c),
    .busy(busy_c), .done(done_c), .overflow(ovf_c),
    .indicator0(i0_c), .indicator1(i1_c), .indicator2(i2_c), .indicator3(i3_c),
    .enable(en_c)
  );

  // Observed display word: {overflow, enable, ind3, ind2, ind1, ind0}
  logic [32:0] obs_a, obs_b, obs_c;
  assign obs_a = {ovf_a, en_a, i3_a, i2_a, i1_a, i0_a};
  assign obs_b = {ovf_b, en_b, i3_b, i2_b, i1_b, i0_b};
  assign obs_c = {ovf_c, en_c, i3_c, i2_c, i1_c, i0_c};

  localparam logic [32:0] RESET_OBS = {1'b0, 4'b0001, 7'b0, 7'b0, 7'b0, 7'b0111111};

  logic [6:0]  seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
  logic [32:0] last_obs [3];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: decimal digits by division, blanking from the most significant non-zero digit
  function automatic logic [32:0] model(input int v, input bit blank);
    int         d [4];
    int         top;
    logic [3:0] en;
    logic [6:0] ind [4];
    if (v > 9999) return {1'b1, 4'b1111, {4{7'b1000000}}};
    d[0] = v % 10;
    d[1] = (v / 10) % 10;
    d[2] = (v / 100) % 10;
    d[3] = v / 1000;
    top = 0;
    for (int k = 0; k < 4; k++) if (d[k] != 0) top = k;
    for (int k = 0; k < 4; k++) begin
      en[k]  = (!blank) || (k <= top);
      ind[k] = en[k] ? seg_tab[d[k]] : 7'b0;
    end
    return {1'b0, en, ind[3], ind[2], ind[1], ind[0]};
  endfunction

  function automatic logic [32:0] get_obs(input int sel);
    case (sel)
      0:       return obs_a;
      1:       return obs_b;
      default: return obs_c;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic get_done(input int sel);
    case (sel)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  task automatic set_in(input int sel, input logic s, input int v);
    case (sel)
      0:       begin start_a = s; value_a = 14'(v); end
      1:       begin start_b = s; value_b = 14'(v); end
      default: begin start_c = s; value_c = 4'(v);  end
    endcase
  endtask

  // One conversion: latency, busy length, held outputs, result, single-cycle done
  task automatic convert(input int sel, input int val);
    int          bw;
    bit          blank;
    int          edges;
    int          busy_cnt;
    bit          seen;
    logic [32:0] exp;
    bw    = (sel == 2) ? 4 : 14;
    blank = (sel != 1);
    exp   = model(val, blank);
    @(negedge clk); set_in(sel, 1'b1, val);
    @(posedge clk); #1;
    set_in(sel, 1'b0, $urandom);
    edges = 1; busy_cnt = 0; seen = 1'b0;
    chk("busy_after_accept", 64'(get_busy(sel)), 64'd1);
    while (!seen && edges < bw + 10) begin
      if (get_busy(sel)) busy_cnt++;
      chk("held_during_conv", 64'(get_obs(sel)), 64'(last_obs[sel]));
      @(posedge clk); #1;
      edges++;
      seen = get_done(sel);
    end
    chk("latency_edges", 64'(edges), 64'(bw + 2));
    chk("busy_cycles", 64'(busy_cnt), 64'(bw + 1));
    chk("busy_low_at_done", 64'(get_busy(sel)), 64'd0);
    chk("result", 64'(get_obs(sel)), 64'(exp));
    last_obs[sel] = exp;
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(get_done(sel)), 64'd0);
    chk("result_held", 64'(get_obs(sel)), 64'(exp));
  endtask

  // Start toggled while busy is ignored; start held into done cycle chains a second run
  task automatic b2b(input int v1, input int v2);
    int  edges;
    bit  seen;
    @(negedge clk); set_in(0, 1'b1, v1);
    @(posedge clk); #1;
    edges = 1; seen = 1'b0;
    while (!seen && edges < 40) begin
      set_in(0, 1'($urandom_range(0, 1)), $urandom_range(0, 16383));
      @(posedge clk); #1;
      edges++;
      seen = done_a;
    end
    chk("b2b_first_latency", 64'(edges), 64'd16);
    chk("b2b_first_result", 64'(obs_a), 64'(model(v1, 1'b1)));
    set_in(0, 1'b1, v2);
    @(posedge clk); #1;
    chk("b2b_accept_busy", 64'(busy_a), 64'd1);
    chk("b2b_accept_done_low", 64'(done_a), 64'd0);
    set_in(0, 1'b0, $urandom_range(0, 16383));
    edges = 1; seen = 1'b0;
    while (!seen && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      seen = done_a;
    end
    chk("b2b_second_latency", 64'(edges), 64'd16);
    chk("b2b_second_result", 64'(obs_a), 64'(model(v2, 1'b1)));
    last_obs[0] = model(v2, 1'b1);
    @(posedge clk); #1;
    chk("b2b_done_one_cycle", 64'(done_a), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 1'b0, 0);
    set_in(1, 1'b0, 0);
    set_in(2, 1'b0, 0);
    for (int s = 0; s < 3; s++) last_obs[s] = RESET_OBS;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_obs_a", 64'(obs_a), 64'(RESET_OBS));
    chk("reset_obs_c", 64'(obs_c), 64'(RESET_OBS));
    chk("reset_busy", 64'(busy_a), 64'd0);
    chk("reset_done", 64'(done_a), 64'd0);
    @(negedge clk); reset = 1'b0;

    // Directed values
    convert(0, 1234);
    convert(0, 7);
    convert(0, 0);
    convert(0, 405);
    convert(0, 10000);
    convert(0, 9999);
    convert(0, 16383);
    convert(0, 1000);
    convert(1, 7);
    convert(2, 15);
    convert(2, 0);

    b2b(3210, 58);

    // Async reset mid-conversion
    @(negedge clk); set_in(0, 1'b1, 8765);
    @(posedge clk); #1; set_in(0, 1'b0, 0);
    repeat (5) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("midreset_obs", 64'(obs_a), 64'(RESET_OBS));
    chk("midreset_busy", 64'(busy_a), 64'd0);
    chk("midreset_done", 64'(done_a), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    for (int s = 0; s < 3; s++) last_obs[s] = RESET_OBS;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("no_done_after_reset", 64'(done_a), 64'd0);
    end
    convert(0, 42);

    // Randomized runs
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) convert(0, $urandom_range(0, 999));
      else                           convert(0, $urandom_range(0, 16383));
    end
    for (int n = 0; n < 10; n++) convert(1, $urandom_range(0, 16383));
    for (int n = 0; n < 10; n++) convert(2, $urandom_range(0, 15));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
